hazard_control_unit: RTL and testbench
======================================

Name: hazard_control_unit

Overview:
- Tracks in-flight register writes across the EX, MEM and WB stages of the Core101 integer pipeline.
- Drives the per-operand forwarding mux selects for the instruction in IS.
- Detects load-use hazards, inserts bubbles and holds the front end while a multi-cycle EX operation is busy.
- Sits between the decode/issue logic and the EX-stage operand muxes, and owns the pipeline stall/bubble decision.

Parameters:
- CNT_W, 16, width of the saturating stall-cycle performance counter.

Ports:
- clk_in  input  1  core clock; all state updates on rising edge
- rst_in  input  1  synchronous, active-high reset
- hcu_issue_valid_in  input  1  valid instruction present in IS
- hcu_rs1_addr_in  input  5  IS source register A
- hcu_rs2_addr_in  input  5  IS source register B
- hcu_rs1_used_in  input  1  IS instruction reads rs1
- hcu_rs2_used_in  input  1  IS instruction reads rs2
- hcu_rd_addr_in  input  5  IS destination register
- hcu_rd_we_in  input  1  IS instruction writes rd
- hcu_is_load_in  input  1  IS instruction is a load (result available end of MEM)
- hcu_ex_busy_in  input  1  multi-cycle op occupying EX, not finished this cycle
- hcu_flush_in  input  1  kill the instructions in IS and EX (branch redirect)
- hcu_stall_out  output  1  hold PC, IF/ID and IS registers this cycle
- hcu_bubble_out  output  1  load a NOP into the EX pipeline register this cycle
- hcu_fwd_a_sel_out  output  2  operand A select: 00 regfile, 01 EX result, 10 MEM result, 11 WB result
- hcu_fwd_b_sel_out  output  2  operand B select, same encoding
- hcu_stall_count_out  output  CNT_W  saturating count of cycles with hcu_stall_out=1

Behaviour:
- State: three stage entries EX, MEM and WB. Each entry holds {valid, rd[4:0], load}. There is also a stall counter.
- Reset (rst_in=1 at edge): all entries cleared (valid=0, rd=0, load=0) and the counter set to 0.
- Outputs are combinational from state and inputs. After reset they are: stall=0, bubble=0, fwd_a=00, fwd_b=00, count=0.
- An entry is "tracked" only if valid=1 and rd!=0. x0 is never tracked, never matched and never forwarded.
- Source match: a source matches when it is used, its address is nonzero and it equals a tracked entry's rd.
- Load-use hazard (lu): issue_valid=1 and either source matches the EX entry with load=1.
- hcu_stall_out = issue_valid & (lu | ex_busy) & !flush. Flush overrides stall in the same cycle.
- hcu_bubble_out = flush | (lu & !ex_busy).
- Forward select per operand, youngest wins:
  - EX match with load=0 → 01;
  - else MEM match → 10;
  - else WB match → 11;
  - else 00.
  - An EX load match gives 00 (the stall covers it).
  - The select is 00 whenever the operand is unused or issue_valid=0.
- Advance rule at each clock edge:
  - If flush: EX ← empty, MEM ← EX, WB ← MEM. The in-flight op is aborted even if ex_busy=1.
  - Else if ex_busy: EX, MEM and WB all hold.
  - Else if stall (load-use): EX ← empty, MEM ← EX, WB ← MEM.
  - Else: EX ← {issue_valid & rd_we & (rd!=0), rd_addr, is_load}, MEM ← EX, WB ← MEM.
- Load-use latency: exactly one stall cycle. On the next cycle the load sits in MEM, the select is 10 and there is no stall.
- Counter: increments by 1 on every cycle with hcu_stall_out=1. It saturates at all-ones and never wraps.
- Simultaneous writers to the same rd in EX/MEM/WB: the priority above guarantees the youngest value is selected.
- Reset mid-operation (during a busy or load stall): all entries are cleared immediately and the next cycle shows no stall and 00 selects.

Test Plan:
- Reset, then issue `add x5` followed by `sub x6,x5,x5` → fwd_a=01, fwd_b=01, stall=0. Two cycles later an instruction reading x5 → fwd_a=10. Three cycles later → 11. Four cycles later → 00.
- `lw x7` then `add x8,x7,x1` → cycle 1: stall=1, bubble=1, fwd_a=00. Cycle 2: stall=0, fwd_a=10. Count = 1.
- `addi x0,…` then an instruction reading x0 → fwd_a=00, stall=0. Also `lw x0` followed by a reader of x0 → no stall.
- `add x3` in MEM and `addi x3` in EX, reader of x3 in IS → fwd_a=01. Repeat with EX empty → 10.
- Hold hcu_ex_busy_in=1 for 4 cycles with a valid IS instruction → stall=1 for all 4 and the entries are unchanged. Count = 4. The first non-busy cycle advances normally.
- `lw x9` in EX with a dependent instruction in IS, plus hcu_flush_in=1 → stall=0, bubble=1. The next cycle has EX empty and x9 in MEM. Separately, assert rst_in during ex_busy → the next cycle has stall=0 and count=0.
- Force 2^CNT_W+3 stall cycles (CNT_W overridden to 4) → count holds at 15.

Source files
------------

// File: rtl/hazard_control_unit.sv
// Core101 hazard control: tracks in-flight writers in EX/MEM/WB, selects operand
// forwarding for the IS instruction and owns the load-use / busy stall-bubble decision.

module hcu_fwd_lane (
  input  logic            issue_valid,
  input  logic            used,
  input  logic [4:0]      addr,
  input  logic [2:0]      trk,
  input  logic [2:0][4:0] rd,
  input  logic            ex_load,
  output logic [1:0]      sel,
  output logic            lu
);
  logic [2:0] hit;

  always_comb begin
    for (int i = 0; i < 3; i++)
      hit[i] = issue_valid && used && (addr != 5'd0) && trk[i] && (rd[i] == addr);
  end

  assign lu = hit[0] & ex_load;

  // Youngest writer wins; a load still in EX has no data yet, so the stall covers it.
  always_comb begin
    sel = 2'b00;
    if (hit[0])      sel = ex_load ? 2'b00 : 2'b01;
    else if (hit[1]) sel = 2'b10;
    else if (hit[2]) sel = 2'b11;
  end
endmodule

module hazard_control_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             hcu_issue_valid_in,
  input  logic [4:0]       hcu_rs1_addr_in,
  input  logic [4:0]       hcu_rs2_addr_in,
  input  logic             hcu_rs1_used_in,
  input  logic             hcu_rs2_used_in,
  input  logic [4:0]       hcu_rd_addr_in,
  input  logic             hcu_rd_we_in,
  input  logic             hcu_is_load_in,
  input  logic             hcu_ex_busy_in,
  input  logic             hcu_flush_in,
  output logic             hcu_stall_out,
  output logic             hcu_bubble_out,
  output logic [1:0]       hcu_fwd_a_sel_out,
  output logic [1:0]       hcu_fwd_b_sel_out,
  output logic [CNT_W-1:0] hcu_stall_count_out
);
  localparam int STAGES = 3;
  localparam int NUM_OPS = 2;

  typedef struct packed {
    logic [4:0] rd;
    logic       load;
  } ent_t;

  // Index 0 = EX, 1 = MEM, 2 = WB.
  logic [STAGES-1:0]        vld_pipe;
  ent_t [STAGES-1:0]        ent;
  logic [STAGES-1:0]        trk;
  logic [STAGES-1:0][4:0]   rd_v;
  logic [NUM_OPS-1:0][4:0]  src_addr;
  logic [NUM_OPS-1:0]       src_used;
  logic [NUM_OPS-1:0][1:0]  sel;
  logic [NUM_OPS-1:0]       lu_v;
  logic                     lu, stall, new_vld;
  ent_t                     new_ent;
  logic [CNT_W-1:0]         cnt;

  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      trk[i]  = vld_pipe[i] && (ent[i].rd != 5'd0);
      rd_v[i] = ent[i].rd;
    end
  end

  assign src_addr = {hcu_rs2_addr_in, hcu_rs1_addr_in};
  assign src_used = {hcu_rs2_used_in, hcu_rs1_used_in};

  genvar g;
  generate
    for (g = 0; g < NUM_OPS; g++) begin : g_op
      hcu_fwd_lane u_lane (
        .issue_valid (hcu_issue_valid_in),
        .used        (src_used[g]),
        .addr        (src_addr[g]),
        .trk         (trk),
        .rd          (rd_v),
        .ex_load     (ent[0].load),
        .sel         (sel[g]),
        .lu          (lu_v[g])
      );
    end
  endgenerate

  assign lu    = |lu_v;
  assign stall = hcu_issue_valid_in & (lu | hcu_ex_busy_in) & ~hcu_flush_in;

  assign hcu_stall_out       = stall;
  assign hcu_bubble_out      = hcu_flush_in | (lu & ~hcu_ex_busy_in);
  assign hcu_fwd_a_sel_out   = sel[0];
  assign hcu_fwd_b_sel_out   = sel[1];
  assign hcu_stall_count_out = cnt;

  // Flush and load-use both inject an empty EX slot; only a clean issue enters EX.
  assign new_vld = ~hcu_flush_in & ~lu & hcu_issue_valid_in & hcu_rd_we_in &
                   (hcu_rd_addr_in != 5'd0);
  assign new_ent = new_vld ? '{rd: hcu_rd_addr_in, load: hcu_is_load_in} : '0;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      vld_pipe <= '0;
      ent      <= '0;
      cnt      <= '0;
    end else begin
      if (stall && (cnt != '1))
        cnt <= cnt + 1'b1;
      // A busy EX freezes the tracker unless a flush aborts the op.
      if (hcu_flush_in || !hcu_ex_busy_in) begin
        vld_pipe <= {vld_pipe[STAGES-2:0], new_vld};
        ent      <= {ent[STAGES-2:0], new_ent};
      end
    end
  end
endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit (CNT_W=4 so counter saturation is reachable).
module tb_hazard_control_unit;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             issue_valid;
  logic [4:0]       rs1, rs2, rd;
  logic             rs1_used, rs2_used, rd_we, is_load, ex_busy, flush;
  logic             stall, bubble;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] count;

  int checks = 0;
  int failures = 0;

  hazard_control_unit #(.CNT_W(CNT_W)) dut (
    .clk_in              (clk),
    .rst_in              (rst),
    .hcu_issue_valid_in  (issue_valid),
    .hcu_rs1_addr_in     (rs1),
    .hcu_rs2_addr_in     (rs2),
    .hcu_rs1_used_in     (rs1_used),
    .hcu_rs2_used_in     (rs2_used),
    .hcu_rd_addr_in      (rd),
    .hcu_rd_we_in        (rd_we),
    .hcu_is_load_in      (is_load),
    .hcu_ex_busy_in      (ex_busy),
    .hcu_flush_in        (flush),
    .hcu_stall_out       (stall),
    .hcu_bubble_out      (bubble),
    .hcu_fwd_a_sel_out   (fwd_a),
    .hcu_fwd_b_sel_out   (fwd_b),
    .hcu_stall_count_out (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic st, input logic bb,
                         input logic [1:0] fa, input logic [1:0] fb);
    chk({tag, ".stall"},  32'(stall),  32'(st));
    chk({tag, ".bubble"}, 32'(bubble), 32'(bb));
    chk({tag, ".fwd_a"},  32'(fwd_a),  32'(fa));
    chk({tag, ".fwd_b"},  32'(fwd_b),  32'(fb));
  endtask

  task automatic issue(input logic v, input logic [4:0] a, input logic ua,
                       input logic [4:0] b, input logic ub,
                       input logic [4:0] d, input logic we, input logic ld);
    issue_valid = v; rs1 = a; rs1_used = ua; rs2 = b; rs2_used = ub;
    rd = d; rd_we = we; is_load = ld;
  endtask

  task automatic idle();
    issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; ex_busy = 1'b0; flush = 1'b0;
    idle();
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    do_reset();

    // Reset state, even with a reader of a register present in IS
    issue(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0);
    settle(); chk_out("reset", 0, 0, 2'b00, 2'b00);
    chk("reset.count", 32'(count), 0);
    tick();
    do_reset();

    // EX -> MEM -> WB -> regfile forwarding of add x5
    issue(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
    settle(); chk_out("add_x5", 0, 0, 2'b00, 2'b00);
    tick();
    issue(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
    settle(); chk_out("sub_ex", 0, 0, 2'b01, 2'b01);
    tick();
    issue(1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0);
    settle(); chk_out("rd_mem", 0, 0, 2'b10, 2'b00);
    tick();
    issue(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    settle(); chk_out("rd_wb", 0, 0, 2'b11, 2'b00);
    tick();
    settle(); chk_out("rd_rf", 0, 0, 2'b00, 2'b00);
    tick();

    // Load-use: exactly one stall cycle, then MEM forward
    do_reset();
    issue(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    settle(); chk_out("lw_x7", 0, 0, 2'b00, 2'b00);
    tick();
    issue(1'b1, 5'd7, 1'b1, 5'd1, 1'b1, 5'd8, 1'b1, 1'b0);
    settle(); chk_out("lu_c1", 1, 1, 2'b00, 2'b00);
    tick();
    settle(); chk_out("lu_c2", 0, 0, 2'b10, 2'b00);
    chk("lu.count", 32'(count), 1);
    tick();
    // The dependent add entered EX after the stall cycle
    issue(1'b1, 5'd8, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0);
    settle(); chk_out("lu_after", 0, 0, 2'b01, 2'b11);
    tick();

    // x0 is never tracked or forwarded
    do_reset();
    issue(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    tick();
    issue(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    settle(); chk_out("x0_alu", 0, 0, 2'b00, 2'b00);
    issue(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    tick();
    issue(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    settle(); chk_out("x0_load", 0, 0, 2'b00, 2'b00);
    tick();

    // Youngest writer wins; then with EX empty MEM is selected
    do_reset();
    issue(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    issue(1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
    tick();
    issue(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0);
    settle(); chk_out("young_ex", 0, 0, 2'b01, 2'b01);
    tick();
    do_reset();
    issue(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    idle();
    tick();
    issue(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    settle(); chk_out("young_mem", 0, 0, 2'b10, 2'b00);
    tick();

    // Multi-cycle EX busy for 4 cycles freezes the tracker
    do_reset();
    issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
    tick();
    issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
    tick();
    issue(1'b1, 5'd10, 1'b1, 5'd4, 1'b1, 5'd11, 1'b1, 1'b0);
    ex_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle(); chk_out($sformatf("busy%0d", i), 1, 0, 2'b01, 2'b10);
      tick();
    end
    ex_busy = 1'b0;
    settle(); chk_out("busy_end", 0, 0, 2'b01, 2'b10);
    chk("busy.count", 32'(count), 4);
    tick();
    issue(1'b1, 5'd4, 1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 1'b0);
    settle(); chk_out("busy_adv", 0, 0, 2'b11, 2'b01);
    tick();

    // Flush overrides a load-use stall and empties EX
    do_reset();
    issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
    tick();
    issue(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0);
    flush = 1'b1;
    settle(); chk_out("flush", 0, 1, 2'b00, 2'b00);
    tick();
    flush = 1'b0;
    issue(1'b1, 5'd9, 1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 1'b0);
    settle(); chk_out("flush_next", 0, 0, 2'b10, 2'b00);
    chk("flush.count", 32'(count), 0);
    tick();

    // Reset in the middle of a busy stall
    do_reset();
    issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0);
    tick();
    issue(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    ex_busy = 1'b1;
    tick();
    settle(); chk_out("busy_pre_rst", 1, 0, 2'b01, 2'b00);
    chk("busy_pre_rst.count", 32'(count), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0; ex_busy = 1'b0;
    settle(); chk_out("busy_rst", 0, 0, 2'b00, 2'b00);
    chk("busy_rst.count", 32'(count), 0);
    tick();

    // Counter saturation: 2^4 + 3 stall cycles
    do_reset();
    issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    ex_busy = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    settle(); chk("sat.count14", 32'(count), 14);
    tick();
    settle(); chk("sat.count15", 32'(count), 15);
    for (int i = 0; i < 4; i++) tick();
    settle(); chk("sat.count19", 32'(count), 15);
    chk("sat.stall", 32'(stall), 1);
    ex_busy = 1'b0;
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
